adc_clk_lock_seq: RTL

Lock supervisor and reset sequencer for the ADC clock PLL. Runs on the free-running 50 MHz board clock, which is also the PLL reference; it must never run on a PLL output. It drives the PLL reset, synchronizes the PLL locked flag, and releases the ADC-domain reset only after a stable-lock window. It retries on lock timeout, counts lock losses in run, and latches a fault after repeated failures.

---
 rtl/adc_clk_pkg.sv | 40 ++++
 rtl/sync_bit.sv | 28 ++
 rtl/adc_clk_lock_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/adc_clk_pkg.sv
// Shared types and sizing helpers for the ADC clock lock supervisor.
//   state_e  : FSM encodings (also exported on the debug/CSR state port)
//   STATE_W  : width of the state encoding
//   RETRY_W  : width of the retry counter
//   clog2    : bit width needed to count 0 .. value-1 (minimum 1)
//   max3     : largest of three values, used to size the shared timer
package adc_clk_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [STATE_W-1:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = unsigned'(i + 1);
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchronizer with asynchronous active-low reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input bit
//   q     : synchronized output, STAGES edges of latency
// STAGES must be at least 2.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/adc_clk_lock_seq.sv
// Lock supervisor and reset sequencer for the ADC clock PLL. Runs on the free-running
// reference clock, pulses the PLL reset, waits for a synchronized lock, requires a
// stable-lock window before releasing the ADC-domain reset, retries on timeout or lock
// drop, counts lock losses while running, and latches a fault after repeated failures.
//   clk              : free-running reference clock (never a PLL output)
//   rst_n            : asynchronous active-low reset
//   pll_locked_async : PLL locked flag, asynchronous to clk
//   fault_clear      : single-cycle request to leave FAULT
//   pll_rst          : active-high PLL reset
//   adc_rst_n        : active-low reset for ADC-clock-domain logic
//   clocks_ready     : high only in RUN
//   fault            : high only in FAULT
//   state            : current FSM encoding
//   retry_cnt        : failed attempts since last RUN or fault clear
//   lock_loss_cnt    : saturating count of lock losses seen in RUN
module adc_clk_lock_seq
    import adc_clk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned STABLE_CYC       = 1024,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned CNT_W            = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked_async,
    input  logic               fault_clear,
    output logic               pll_rst,
    output logic               adc_rst_n,
    output logic               clocks_ready,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [CNT_W-1:0]   lock_loss_cnt
);

    localparam int unsigned TIMER_W = clog2(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC));

    localparam logic [TIMER_W-1:0] RstLast     = TIMER_W'(RST_PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0] TimeoutLast = TIMER_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] StableLast  = TIMER_W'(STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RetryLimit  = RETRY_W'(MAX_RETRIES);

    logic locked_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked_async),
        .q     (locked_s)
    );

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic               pll_rst_q, adc_rst_n_q, ready_q, fault_q;

    // Shared by WAIT_LOCK timeout and STABLE lock drop: retry until the limit, then fault.
    function automatic void fail_attempt(input logic [RETRY_W-1:0] retry_in,
                                         output state_e nxt,
                                         output logic [RETRY_W-1:0] retry_out);
        if (retry_in < RetryLimit) begin
            nxt       = StPllRst;
            retry_out = retry_in + RETRY_W'(1);
        end else begin
            nxt       = StFault;
            retry_out = retry_in;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            StPllRst: begin
                if (timer_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = StStable;
                end else if (timer_q == TimeoutLast) begin
                    fail_attempt(retry_q, state_d, retry_d);
                end
            end
            StStable: begin
                if (!locked_s) begin
                    fail_attempt(retry_q, state_d, retry_d);
                end else if (timer_q == StableLast) begin
                    state_d = StRun;
                    retry_d = '0;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d = StPllRst;
                    loss_d  = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);
                end
            end
            StFault: begin
                if (fault_clear) begin
                    state_d = StPllRst;
                    retry_d = '0;
                end
            end
            default: state_d = StPllRst;
        endcase

        // Timer restarts on every state change; it only matters in the timed states.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == StPllRst || state_q == StWaitLock || state_q == StStable) begin
            timer_d = timer_q + TIMER_W'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPllRst;
            timer_q     <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            adc_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            // Outputs decoded from next state so they move on the same edge as state.
            pll_rst_q   <= (state_d == StPllRst) || (state_d == StFault);
            adc_rst_n_q <= (state_d == StRun);
            ready_q     <= (state_d == StRun);
            fault_q     <= (state_d == StFault);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign adc_rst_n     = adc_rst_n_q;
    assign clocks_ready  = ready_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule
